parity_serial_tx: RTL and testbench

PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

---
 rtl/parity_serial_tx.sv | 133 +++++++++++++
 tb/tb_parity_serial_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: start + 8 data (LSB first) + even parity + stop serial transmitter
// with a one-entry holding register. Define PARITY_SERIAL_TX_STOP2_EN for a second stop bit.
module parity_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       parity_out
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef PARITY_SERIAL_TX_STOP2_EN
  localparam logic [2:0] STOP2  = 3'd5;
`endif
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shifter;
  logic [7:0]  hold_reg;
  logic        hold_full;

  logic        accept;
  logic        bit_end;
  logic        frame_end;
  logic        load_hold;
  logic        drain;
  logic        hold_full_nxt;
  logic        start_frame;
  logic [7:0]  start_byte;

  always_comb begin
    accept    = data_valid && data_ready;
    bit_end   = (bit_cnt == BIT_LAST);
`ifdef PARITY_SERIAL_TX_STOP2_EN
    frame_end = (state == STOP2) && bit_end;
`else
    frame_end = (state == STOP) && bit_end;
`endif
    // An idle transmitter with an empty holding register takes the byte straight into the shifter.
    load_hold     = accept && (state != IDLE);
    drain         = hold_full && ((state == IDLE) || frame_end);
    hold_full_nxt = load_hold || (hold_full && !drain);
    start_frame   = drain || (accept && (state == IDLE));
    start_byte    = hold_full ? hold_reg : data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      data_ready <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      // data_ready is registered from the next holding state, so it is already low while a drain is pending.
      hold_full  <= hold_full_nxt;
      data_ready <= !hold_full_nxt;
      if (load_hold) hold_reg <= data_in;

      if (start_frame) begin
        state      <= START;
        shifter    <= start_byte;
        parity_out <= ^start_byte;
        tx_out     <= 1'b0;
        busy       <= 1'b1;
        bit_cnt    <= '0;
        bit_idx    <= '0;
      end else if (state != IDLE) begin
        if (!bit_end) begin
          bit_cnt <= bit_cnt + 16'd1;
        end else begin
          bit_cnt <= '0;
          case (state)
            START: begin
              state  <= DATA;
              tx_out <= shifter[0];
            end
            DATA: begin
              if (bit_idx == 3'd7) begin
                state  <= PARITY;
                tx_out <= parity_out;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                shifter <= {1'b0, shifter[7:1]};
                tx_out  <= shifter[1];
              end
            end
            PARITY: begin
              state  <= STOP;
              tx_out <= 1'b1;
            end
`ifdef PARITY_SERIAL_TX_STOP2_EN
            STOP: begin
              state <= STOP2;
            end
            STOP2: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            STOP: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`endif
            default: begin
              state  <= IDLE;
              busy   <= 1'b0;
              tx_out <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench for parity_serial_tx: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, a line decoder, and randomized traffic.
module tb_parity_serial_tx;

  localparam int CPB = 4;
`ifdef PARITY_SERIAL_TX_STOP2_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, tx_out, busy, parity_out;

  int n_cmp = 0;
  int n_mis = 0;

  parity_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .parity_out (parity_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a bit vector played out CPB cycles per bit.
  logic        m_busy = 1'b0;
  logic        m_hold_v = 1'b0;
  logic        m_rdy = 1'b0;
  logic        m_par = 1'b0;
  logic [7:0]  m_hold = 8'h00;
  logic [11:0] m_bits = '1;
  int          m_pos = 0;

  function automatic void model_start(input logic [7:0] b);
    m_busy = 1'b1;
    m_pos  = 0;
    m_par  = ^b;
    m_bits = {2'b11, ^b, b, 1'b0};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_hold_v = 1'b0; m_rdy = 1'b0; m_par = 1'b0; m_pos = 0;
    end else begin
      logic acc, hv, ending;
      acc    = data_valid && m_rdy;
      hv     = m_hold_v;
      ending = m_busy && (m_pos == NB*CPB - 1);
      if (m_busy && !ending) m_pos++;
      if (acc && m_busy) begin m_hold = data_in; m_hold_v = 1'b1; end
      if (!m_busy) begin
        if (hv) begin model_start(m_hold); m_hold_v = 1'b0; end
        else if (acc) model_start(data_in);
      end else if (ending) begin
        if (hv) begin model_start(m_hold); m_hold_v = 1'b0; end
        else m_busy = 1'b0;
      end
      m_rdy = !m_hold_v;
    end
  end

  always @(negedge clk) begin
    chk("tx_out", tx_out, m_busy ? m_bits[m_pos / CPB] : 1'b1);
    chk("busy", busy, m_busy);
    chk("data_ready", data_ready, m_rdy);
    chk("parity_out", parity_out, m_par);
  end

  // Independent line decoder: samples mid-bit and queues every received data byte.
  logic [7:0] dq[$];
  logic [7:0] d_sh = 8'h00;
  logic       d_act = 1'b0;
  int         d_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n) d_act = 1'b0;
    else if (!d_act) begin
      if (tx_out == 1'b0) begin d_act = 1'b1; d_cnt = 0; end
    end else begin
      d_cnt++;
      if (d_cnt % CPB == CPB/2) begin
        int k;
        k = d_cnt / CPB;
        if (k >= 1 && k <= 8) d_sh[k-1] = tx_out;
        if (k == 10) begin dq.push_back(d_sh); d_act = 1'b0; end
      end
    end
  end

  // Called at a negedge; returns on the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    data_in = b;
    data_valid = 1'b1;
    while (!data_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("send_timeout", 1, 0);
    @(negedge clk);
    data_valid = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic run_frame(input string nm, input logic [11:0] exp_bits, input logic exp_par);
    logic [11:0] s;
    int c;
    s = '1;
    c = 0;
    chk({nm, "_parity_out"}, parity_out, exp_par);
    while (busy && c < 200) begin
      if (c % CPB == 0 && c / CPB < 12) s[c / CPB] = tx_out;
      c++;
      @(negedge clk);
    end
    chk({nm, "_bits"}, s, exp_bits);
    chk({nm, "_busy_cycles"}, c, NB*CPB);
  endtask

  initial begin
    int c;
    logic [7:0] bp_exp [3];
    bp_exp[0] = 8'h11; bp_exp[1] = 8'h22; bp_exp[2] = 8'h55;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_parity", parity_out, 1'b0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", data_ready, 1'b1);

    send(8'hA5); run_frame("a5", 12'b110101001010, 1'b0);
    send(8'h01); run_frame("x01", 12'b111000000010, 1'b1);
    send(8'h00); run_frame("x00", 12'b110000000000, 1'b0);
    @(negedge clk);

    send(8'h3C);
    repeat (15) @(negedge clk);
    send(8'hC3);
    chk("b2b_ready_low", data_ready, 1'b0);
    c = 16;
    while (busy && c < 400) begin
      if (c == NB*CPB - 2) chk("b2b_ready_drain", data_ready, 1'b0);
      if (c == NB*CPB - 1) chk("b2b_last_stop", tx_out, 1'b1);
      if (c == NB*CPB)     chk("b2b_next_start", tx_out, 1'b0);
      c++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", c, 2*NB*CPB);
    @(negedge clk);

    dq.delete();
    send(8'h11);
    send(8'h22);
    send(8'h55);
    wait_idle();
    chk("bp_frames", dq.size(), 3);
    for (int i = 0; i < dq.size() && i < 3; i++) chk("bp_byte", dq[i], bp_exp[i]);

    send(8'h5A);
    repeat (17) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_out, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", data_ready, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_rel", data_ready, 1'b1);
    dq.delete();
    send(8'h81); run_frame("x81", 12'b110100000010, 1'b0);
    chk("x81_decoded_n", dq.size(), 1);
    if (dq.size() > 0) chk("x81_decoded", dq[0], 8'h81);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      data_valid = ($urandom_range(0, 2) == 0);
      data_in = 8'($urandom);
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
      end
    end
    data_valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
